// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST controller: state encoding,
// default post-reset memory content and fail counter sizing.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST_RD = 3'd1,
        WR     = 3'd2,
        RD     = 3'd3,
        INV_WR = 3'd4,
        INV_RD = 3'd5,
        DRAIN  = 3'd6,
        DONE   = 3'd7
    } state_t;

    localparam logic [7:0] RST_VAL_DEFAULT = 8'hFF;

    localparam int FAIL_CNT_W = 8;
    localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-compare stage of the memory BIST: a 1-deep pending compare that
// lines up the expected value with the memory's 1-cycle read latency,
// plus the saturating miscompare counter and first-fail address capture.
import mem_bist_pkg::*;

module mem_bist_cmp #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  issue,
    input  logic [DATA_W-1:0]     exp_data,
    input  logic [ADDR_W-1:0]     issue_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic [ADDR_W-1:0]     first_fail_addr
);

    logic              pend_vld;
    logic [DATA_W-1:0] pend_exp;
    logic [ADDR_W-1:0] pend_addr;
    logic              miscompare;

    assign miscompare = pend_vld && (rd_data != pend_exp);

    // Hold the expectation of the read issued this cycle until its data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_exp  <= '0;
            pend_addr <= '0;
        end else if (clear) begin
            pend_vld  <= 1'b0;
            pend_exp  <= '0;
            pend_addr <= '0;
        end else begin
            pend_vld  <= issue;
            pend_exp  <= exp_data;
            pend_addr <= issue_addr;
        end
    end

    // Count miscompares (saturating) and remember where the first one happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt        <= '0;
            first_fail_addr <= '0;
        end else if (clear) begin
            fail_cnt        <= '0;
            first_fail_addr <= '0;
        end else if (miscompare) begin
            if (fail_cnt != FAIL_CNT_MAX) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
            if (fail_cnt == '0) begin
                first_fail_addr <= pend_addr;
            end
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller top: sequences reset-content check, seeded pattern
// write and read-back against a single-port memory with 1-cycle read latency.
// Build option MEM_BIST_INV_PASS_EN adds an inverted-pattern write/read pass.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start, memory port parked
//   RST_RD | read every address, expect RST_VAL
//   WR     | write seed+addr to every address
//   RD     | read every address, expect seed+addr
//   INV_WR | write ~(seed+addr) (MEM_BIST_INV_PASS_EN only)
//   INV_RD | read every address, expect ~(seed+addr) (MEM_BIST_INV_PASS_EN only)
//   DRAIN  | one idle cycle to retire the last pending compare
//   DONE   | results valid and held; start accepted again
import mem_bist_pkg::*;

module mem_bist_ctrl #(
    parameter int              ADDR_W  = 3,
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(RST_VAL_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     seed,
    output logic                  mem_enable,
    output logic                  mem_rd_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wr_data,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic [ADDR_W-1:0]     first_fail_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] pattern;
    logic              accept;
    logic              rd_wr_int;
    logic              cmp_issue;
    logic [DATA_W-1:0] cmp_exp;

    assign pattern = seed_q + DATA_W'(addr_q);

    // State, address counter and latched seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seed_q  <= seed_d;
        end
    end

    // Next-state, address sequencing and memory port drive.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        accept      = 1'b0;
        mem_enable  = 1'b0;
        rd_wr_int   = 1'b1;
        mem_addr    = '0;
        mem_wr_data = '0;
        cmp_issue   = 1'b0;
        cmp_exp     = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RST_RD;
                    addr_d  = '0;
                    seed_d  = seed;
                end
            end
            RST_RD: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q;
                cmp_issue  = 1'b1;
                cmp_exp    = RST_VAL;
                addr_d     = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = WR;
            end
            WR: begin
                mem_enable  = 1'b1;
                rd_wr_int   = 1'b0;
                mem_addr    = addr_q;
                mem_wr_data = pattern;
                addr_d      = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = RD;
            end
            RD: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q;
                cmp_issue  = 1'b1;
                cmp_exp    = pattern;
                addr_d     = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
`ifdef MEM_BIST_INV_PASS_EN
                    state_d = INV_WR;
`else
                    state_d = DRAIN;
`endif
                end
            end
`ifdef MEM_BIST_INV_PASS_EN
            INV_WR: begin
                mem_enable  = 1'b1;
                rd_wr_int   = 1'b0;
                mem_addr    = addr_q;
                mem_wr_data = ~pattern;
                addr_d      = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = INV_RD;
            end
            INV_RD: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q;
                cmp_issue  = 1'b1;
                cmp_exp    = ~pattern;
                addr_d     = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = DRAIN;
            end
`endif
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // rd_wr idles high, but every output reads 0 while reset is held.
    assign mem_rd_wr = rd_wr_int & ~rst;

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);
    assign pass = done && (fail_cnt == '0);

    mem_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk             (clk),
        .rst             (rst),
        .clear           (accept),
        .issue           (cmp_issue),
        .exp_data        (cmp_exp),
        .issue_addr      (mem_addr),
        .rd_data         (mem_rd_data),
        .fail_cnt        (fail_cnt),
        .first_fail_addr (first_fail_addr)
    );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: an 8x8 registered-read memory beside the DUT,
// a table of directed runs, a reset-abort sequence and randomized runs
// checked against a whole-run result model.
module tb_mem_bist_ctrl;
    import mem_bist_pkg::*;

    localparam int DEPTH = 8;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int NPH = 5;
`else
    localparam int NPH = 3;
`endif
    localparam int BUSY_LEN = NPH * DEPTH + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       mem_enable, mem_rd_wr;
    logic [2:0] mem_addr;
    logic [7:0] mem_wr_data, mem_rd_data;
    logic       busy, done, pass;
    logic [7:0] fail_cnt;
    logic [2:0] first_fail_addr;

    mem_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed_in),
        .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .first_fail_addr(first_fail_addr)
    );

    initial forever #5 clk = ~clk;

    // Memory with fault injection: flips bit0 on the first read of corrupt_addr after a write.
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    logic       flip_q, wr_seen, corrupt_used;
    logic       corrupt_en = 1'b0;
    logic [2:0] corrupt_addr = 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
            rd_q <= 8'h00; flip_q <= 1'b0; wr_seen <= 1'b0; corrupt_used <= 1'b0;
        end else begin
            flip_q <= 1'b0;
            if (start) begin
                wr_seen <= 1'b0; corrupt_used <= 1'b0;
            end
            if (mem_enable && !mem_rd_wr) begin
                mem[mem_addr] <= mem_wr_data;
                wr_seen <= 1'b1;
            end else if (mem_enable) begin
                rd_q <= mem[mem_addr];
                if (corrupt_en && wr_seen && !corrupt_used && mem_addr == corrupt_addr) begin
                    flip_q <= 1'b1; corrupt_used <= 1'b1;
                end
            end
        end
    end
    assign mem_rd_data = rd_q ^ {7'b0, flip_q};

    int tests = 0, fails = 0;
    logic [7:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; #1;
        check("rst_busy", busy, 0);  check("rst_done", done, 0);
        check("rst_pass", pass, 0);  check("rst_fail_cnt", fail_cnt, 0);
        check("rst_ffa", first_fail_addr, 0); check("rst_enable", mem_enable, 0);
        check("rst_rd_wr", mem_rd_wr, 0); check("rst_addr", mem_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'hFF;
        #1 check("idle_rd_wr", mem_rd_wr, 1);
    endtask

    // Whole-run expectation: RST_RD misses, then the injected RD miss; memory ends with the pattern.
    task automatic model_run(input logic [7:0] s, input logic cen, input logic [2:0] ca,
                             output int ef, output int effa);
        ef = 0; effa = 0;
        for (int a = 0; a < DEPTH; a++)
            if (model_mem[a] != 8'hFF) begin
                if (ef == 0) effa = a;
                if (ef < 255) ef++;
            end
        if (cen) begin
            if (ef == 0) effa = ca;
            if (ef < 255) ef++;
        end
        for (int a = 0; a < DEPTH; a++)
`ifdef MEM_BIST_INV_PASS_EN
            model_mem[a] = ~(s + 8'(a));
`else
            model_mem[a] = s + 8'(a);
`endif
    endtask

    // Start a run, count busy cycles and check the memory port protocol cycle by cycle.
    task automatic do_run(input logic [7:0] s, input int pulse_at, output int blen, output int perr);
        int n, ph, a;
        logic [7:0] e;
        @(negedge clk); seed_in = s; start = 1'b1;
        @(negedge clk); start = 1'b0; seed_in = 8'($urandom);
        blen = 0; perr = 0; n = 0;
        while (busy === 1'b1 && n < 300) begin
            blen++; n++;
            ph = (blen - 1) / DEPTH; a = (blen - 1) % DEPTH;
            if (blen == BUSY_LEN) begin
                if (mem_enable !== 1'b0 || mem_rd_wr !== 1'b1 || mem_addr !== 3'd0) perr++;
            end else if (blen > BUSY_LEN) begin
                perr++;
            end else begin
                e = s + 8'(a);
                if (mem_enable !== 1'b1 || mem_addr !== 3'(a)) perr++;
                if (ph == 1 || ph == 3) begin
                    if (mem_rd_wr !== 1'b0 || mem_wr_data !== (ph == 3 ? ~e : e)) perr++;
                end else if (mem_rd_wr !== 1'b1) perr++;
            end
            start = (blen == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL busy_timeout: got %0d cycles, expected %0d", n, BUSY_LEN);
        end
        if (mem_enable !== 1'b0 || mem_rd_wr !== 1'b1 || mem_addr !== 3'd0 || mem_wr_data !== 8'd0) perr++;
    endtask

    function automatic int mem_bad(input logic [7:0] s);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++)
`ifdef MEM_BIST_INV_PASS_EN
            if (mem[a] !== ~(s + 8'(a))) bad++;
`else
            if (mem[a] !== s + 8'(a)) bad++;
`endif
        return bad;
    endfunction

    typedef struct {
        logic       do_rst;
        logic [7:0] seed;
        logic       cen;
        logic [2:0] ca;
        int         pulse_at;
        int         fcnt;
        int         ffa;
        logic       pass;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int blen, perr, ef, effa, n;
        logic [7:0] s;
        logic       cen;
        logic [2:0] ca;

        vecs[0] = '{1'b1, 8'h00, 1'b0, 3'd0, -1, 0, 0, 1'b1};
`ifdef MEM_BIST_INV_PASS_EN
        vecs[1] = '{1'b0, 8'h00, 1'b0, 3'd0, -1, 7, 1, 1'b0};
`else
        vecs[1] = '{1'b0, 8'h00, 1'b0, 3'd0, -1, 8, 0, 1'b0};
`endif
        vecs[2] = '{1'b1, 8'h5A, 1'b1, 3'd5, -1, 1, 5, 1'b0};
        vecs[3] = '{1'b1, 8'hFC, 1'b0, 3'd0, -1, 0, 0, 1'b1};
        vecs[4] = '{1'b1, 8'h33, 1'b0, 3'd0,  3, 0, 0, 1'b1};

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_rst) do_reset();
            corrupt_en = vecs[v].cen; corrupt_addr = vecs[v].ca;
            model_run(vecs[v].seed, vecs[v].cen, vecs[v].ca, ef, effa);
            do_run(vecs[v].seed, vecs[v].pulse_at, blen, perr);
            check($sformatf("v%0d_busy_len", v), blen, BUSY_LEN);
            check($sformatf("v%0d_done", v), done, 1);
            check($sformatf("v%0d_pass", v), pass, vecs[v].pass);
            check($sformatf("v%0d_fail_cnt", v), fail_cnt, vecs[v].fcnt);
            check($sformatf("v%0d_ffa", v), first_fail_addr, vecs[v].ffa);
            check($sformatf("v%0d_protocol", v), perr, 0);
            check($sformatf("v%0d_mem", v), mem_bad(vecs[v].seed), 0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_sticky_done", v), done, 1);
            check($sformatf("v%0d_sticky_cnt", v), fail_cnt, vecs[v].fcnt);
        end
        corrupt_en = 1'b0;

        // Reset while writing address 3 aborts the run immediately.
        do_reset();
        @(negedge clk); seed_in = 8'h21; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(mem_enable === 1'b1 && mem_rd_wr === 1'b0 && mem_addr === 3'd3) && n < 40) begin
            @(negedge clk); n++;
        end
        check("abort_reached_wr3", n < 40, 1);
        rst = 1'b1; #1;
        check("abort_busy", busy, 0); check("abort_done", done, 0);
        check("abort_pass", pass, 0); check("abort_enable", mem_enable, 0);
        check("abort_rd_wr", mem_rd_wr, 0); check("abort_addr", mem_addr, 0);
        check("abort_wr_data", mem_wr_data, 0); check("abort_fail_cnt", fail_cnt, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'hFF;
        model_run(8'h44, 1'b0, 3'd0, ef, effa);
        do_run(8'h44, -1, blen, perr);
        check("post_abort_busy_len", blen, BUSY_LEN);
        check("post_abort_pass", pass, 1);
        check("post_abort_fail_cnt", fail_cnt, 0);

        // Randomized runs against the result model.
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) do_reset();
            s = 8'($urandom); cen = 1'($urandom_range(0, 1)); ca = 3'($urandom_range(0, 7));
            corrupt_en = cen; corrupt_addr = ca;
            model_run(s, cen, ca, ef, effa);
            do_run(s, -1, blen, perr);
            check($sformatf("r%0d_busy_len", r), blen, BUSY_LEN);
            check($sformatf("r%0d_fail_cnt", r), fail_cnt, ef);
            check($sformatf("r%0d_ffa", r), first_fail_addr, effa);
            check($sformatf("r%0d_pass", r), pass, ef == 0);
            check($sformatf("r%0d_protocol", r), perr, 0);
            for (int a = 0; a < DEPTH; a++)
                check($sformatf("r%0d_mem%0d", r, a), mem[a], model_mem[a]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
